rf_riscv: RTL and testbench

RF_RISCV -- requirements
Module: rf_riscv

---
 rtl/rf_riscv_pkg.sv | 15 +
 rtl/rf_riscv.sv | 61 ++++++
 tb/tb_rf_riscv.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rf_riscv_pkg.sv
// Shared core constants used by the register file and the ALU.
// Keeping them here means both blocks agree on operand width and register indexing.
package rf_riscv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_riscv.sv
// RISC-V integer register file: two combinational read ports, one synchronous write port.
// Build option RF_BYPASS_EN forwards a same-cycle write to a matching read port.
module rf_riscv #(
  parameter int DATA_WIDTH = rf_riscv_pkg::DATA_WIDTH,
  parameter int REG_COUNT  = rf_riscv_pkg::REG_COUNT
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                write_enable_i,
  input  logic [rf_riscv_pkg::REG_ADDR_W-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0]               write_data_i,
  input  logic [rf_riscv_pkg::REG_ADDR_W-1:0] read_addr1_i,
  input  logic [rf_riscv_pkg::REG_ADDR_W-1:0] read_addr2_i,
  output logic [DATA_WIDTH-1:0]               read_data1_o,
  output logic [DATA_WIDTH-1:0]               read_data2_o
);
  import rf_riscv_pkg::*;

  // x0 has no storage; the array starts at x1.
  logic [DATA_WIDTH-1:0] r_regs [1:REG_COUNT-1];
  logic                  w_wr_valid;

  assign w_wr_valid = write_enable_i && !is_zero_reg(write_addr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[write_addr_i] <= write_data_i;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [REG_ADDR_W-1:0] addr
  );
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (!is_zero_reg(addr)) begin
      value = r_regs[addr];
`ifdef RF_BYPASS_EN
      if (w_wr_valid && (write_addr_i == addr)) begin
        value = write_data_i;
      end
`endif
    end
    return value;
  endfunction

  // Outputs are forced to zero during reset so a forwarded write cannot leak through.
  always_comb begin
    read_data1_o = '0;
    read_data2_o = '0;
    if (rst_ni) begin
      read_data1_o = read_port(read_addr1_i);
      read_data2_o = read_port(read_addr2_i);
    end
  end

endmodule

// File: tb/tb_rf_riscv.sv
// Directed self-checking bench for rf_riscv; expected values are hand-computed constants.
// Build with +define+RF_BYPASS_EN to check the forwarding variant.
module tb_rf_riscv;

  logic        clk_i;
  logic        rst_ni;
  logic        write_enable_i;
  logic [4:0]  write_addr_i;
  logic [31:0] write_data_i;
  logic [4:0]  read_addr1_i;
  logic [4:0]  read_addr2_i;
  logic [31:0] read_data1_o;
  logic [31:0] read_data2_o;

  int n_checks = 0;
  int n_pass   = 0;

  rf_riscv dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .write_enable_i (write_enable_i),
    .write_addr_i   (write_addr_i),
    .write_data_i   (write_data_i),
    .read_addr1_i   (read_addr1_i),
    .read_addr2_i   (read_addr2_i),
    .read_data1_o   (read_data1_o),
    .read_data2_o   (read_data2_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive a one-cycle write; inputs change on the falling edge, commit on the next rising edge.
  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    write_enable_i = 1'b1;
    write_addr_i   = addr;
    write_data_i   = data;
    @(negedge clk_i);
    write_enable_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    read_addr1_i = a1;
    read_addr2_i = a2;
    #1;
  endtask

  logic [31:0] exp_v;
  logic [31:0] sum;

  initial begin
    rst_ni         = 1'b0;
    write_enable_i = 1'b0;
    write_addr_i   = '0;
    write_data_i   = '0;
    read_addr1_i   = 5'd1;
    read_addr2_i   = 5'd31;
    #1;
    chk("reset_rd1", read_data1_o, 32'h0);
    chk("reset_rd2", read_data2_o, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Asynchronous reset mid-cycle after x5 is loaded.
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    chk("x5_loaded", read_data1_o, 32'hDEADBEEF);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_reset_rd1", read_data1_o, 32'h0);
    chk("async_reset_rd2", read_data2_o, 32'h0);
    @(negedge clk_i);
    // Write attempted while in reset must be lost.
    write_enable_i = 1'b1;
    write_addr_i   = 5'd6;
    write_data_i   = 32'h66666666;
    @(negedge clk_i);
    write_enable_i = 1'b0;
    rst_ni = 1'b1;
    rd(5'd6, 5'd5);
    chk("write_in_reset_lost", read_data1_o, 32'h0);
    chk("x5_after_reset", read_data2_o, 32'h0);
    wr(5'd6, 32'h66666666);
    rd(5'd6, 5'd6);
    chk("first_write_after_reset", read_data1_o, 32'h66666666);

    // Zero register.
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    chk("x0_rd1", read_data1_o, 32'h0);
    chk("x0_rd2", read_data2_o, 32'h0);

    // Basic write/read feeding an ADD.
    wr(5'd1, 32'h00000007);
    wr(5'd2, 32'hFFFFFFF9);
    rd(5'd1, 5'd2);
    chk("x1_rd1", read_data1_o, 32'h00000007);
    chk("x2_rd2", read_data2_o, 32'hFFFFFFF9);
    sum = read_data1_o + read_data2_o;
    chk("alu_add", sum, 32'h0);

    // Same-cycle read of the write target.
    wr(5'd3, 32'h11111111);
    @(negedge clk_i);
    read_addr1_i   = 5'd3;
    read_addr2_i   = 5'd3;
    write_enable_i = 1'b1;
    write_addr_i   = 5'd3;
    write_data_i   = 32'h22222222;
    #1;
`ifdef RF_BYPASS_EN
    exp_v = 32'h22222222;
`else
    exp_v = 32'h11111111;
`endif
    chk("same_cycle_rd1", read_data1_o, exp_v);
    chk("same_cycle_rd2", read_data2_o, exp_v);
    // Write to x0 with matching read address must never forward.
    write_addr_i = 5'd0;
    read_addr2_i = 5'd0;
    #1;
    chk("x0_no_forward", read_data2_o, 32'h0);
    write_addr_i = 5'd3;
    @(negedge clk_i);
    write_enable_i = 1'b0;
    #1;
    chk("next_cycle_x3", read_data1_o, 32'h22222222);

    // Write disabled, including unknown address.
    wr(5'd4, 32'h44444444);
    @(negedge clk_i);
    write_enable_i = 1'b0;
    write_addr_i   = 5'd4;
    write_data_i   = 32'hA5A5A5A5;
    @(negedge clk_i);
    write_addr_i   = 5'bxxxxx;
    @(negedge clk_i);
    rd(5'd4, 5'd3);
    chk("we0_x4_unchanged", read_data1_o, 32'h44444444);
    chk("we0_x3_unchanged", read_data2_o, 32'h22222222);

    // Full sweep.
    for (int k = 1; k < 32; k++) begin
      wr(k[4:0], k * 32'h01010101);
    end
    for (int k = 1; k < 32; k++) begin
      rd(k[4:0], 5'(32 - k));
      chk($sformatf("sweep_p1_x%0d", k), read_data1_o, k * 32'h01010101);
      chk($sformatf("sweep_p2_x%0d", 32 - k), read_data2_o, (32 - k) * 32'h01010101);
    end
    rd(5'd0, 5'd31);
    chk("sweep_x0", read_data1_o, 32'h0);
    chk("sweep_x31", read_data2_o, 32'h1F1F1F1F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
